// File: rtl/dsc_s2b_capture.sv
// dsc_s2b_capture
// Receive-side controller for the deterministic stochastic multiplier.
// Opens a frame by enabling the stochastic number generators, counts the
// 1s of the product bitstream, and closes the frame on the generator's
// done flag or on a frame-length timeout. The binary count is then
// offered to the consumer on a valid/ready handshake.
//
// Frame length: cyc starts at 0 on the first COUNT cycle. The frame times
// out on the COUNT cycle that sees cyc at its terminal all-ones value, so
// a frame without done_in lasts 2^OUT_WIDTH COUNT cycles. Both counters
// stop at all-ones and never wrap.

module dsc_s2b_capture #(
    parameter int SNG_WIDTH  = 10,
    parameter int NUM_INPUTS = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                start,
    input  logic                                sn_in,
    input  logic                                done_in,
    output logic                                gen_en,
    output logic                                busy,
    output logic [SNG_WIDTH*NUM_INPUTS-1:0]     result,
    output logic                                result_valid,
    input  logic                                result_ready,
    output logic                                sat,
    output logic                                timeout
);

    localparam int OUT_WIDTH = SNG_WIDTH * NUM_INPUTS;

    localparam logic [OUT_WIDTH-1:0] ALL_ONES = '1;
    localparam logic [OUT_WIDTH-1:0] ONE      = OUT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARM   = 2'd1,
        COUNT = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t               state;
    state_t               state_next;

    logic [OUT_WIDTH-1:0] acc;
    logic [OUT_WIDTH-1:0] cyc;
    logic                 sat_q;
    logic                 timeout_q;

    logic                 frame_open;
    logic                 cyc_terminal;
    logic                 acc_full;
    logic                 frame_close;

    // Decoded conditions shared by the next-state logic and the datapath
    always_comb begin
        frame_open   = (state == IDLE) && start;
        cyc_terminal = (cyc == ALL_ONES);
        acc_full     = (acc == ALL_ONES);
        frame_close  = (state == COUNT) && (done_in || cyc_terminal);
    end

    // State register; reset aborts any frame in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; start is only looked at in IDLE
    always_comb begin
        state_next   = state;
        gen_en       = 1'b0;
        busy         = 1'b0;
        result_valid = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_next = ARM;
                end
            end

            ARM: begin
                gen_en     = 1'b1;
                busy       = 1'b1;
                state_next = COUNT;
            end

            COUNT: begin
                gen_en = 1'b1;
                busy   = 1'b1;
                if (done_in || cyc_terminal) begin
                    state_next = HOLD;
                end
            end

            HOLD: begin
                result_valid = 1'b1;
                if (result_ready) begin
                    state_next = IDLE;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Accumulator: cleared on frame open, saturating count of sn_in in COUNT
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (frame_open) begin
            acc <= '0;
        end else if ((state == COUNT) && sn_in && !acc_full) begin
            acc <= acc + ONE;
        end
    end

    // Cycle counter: counts COUNT cycles and parks at its terminal value
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cyc <= '0;
        end else if (frame_open) begin
            cyc <= '0;
        end else if ((state == COUNT) && !cyc_terminal) begin
            cyc <= cyc + ONE;
        end
    end

    // Sticky saturation flag: a 1 arrived while the accumulator was full
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_q <= 1'b0;
        end else if (frame_open) begin
            sat_q <= 1'b0;
        end else if ((state == COUNT) && sn_in && acc_full) begin
            sat_q <= 1'b1;
        end
    end

    // Timeout flag: frame closed by length limit; done_in takes priority
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            timeout_q <= 1'b0;
        end else if (frame_open) begin
            timeout_q <= 1'b0;
        end else if (frame_close && !done_in) begin
            timeout_q <= 1'b1;
        end
    end

    // The accumulator only moves during COUNT, so it already holds the
    // result from the close of the frame until the next start
    always_comb begin
        result  = acc;
        sat     = sat_q;
        timeout = timeout_q;
    end

endmodule

// File: tb/tb_dsc_s2b_capture.sv
// tb_dsc_s2b_capture
// Self-checking bench for dsc_s2b_capture with OUT_WIDTH=4. Each frame is
// described by a 16-bit sn_in pattern (bit k is sn_in on COUNT cycle k),
// the COUNT cycle on which done_in fires (or none), a backpressure length
// and whether start is poked while the block is busy. Expected results
// come from counting ones in the pattern up to the closing cycle.

module tb_dsc_s2b_capture;

    localparam int SNG_WIDTH  = 2;
    localparam int NUM_INPUTS = 2;
    localparam int OUT_WIDTH  = SNG_WIDTH * NUM_INPUTS;
    localparam int MAX_VAL    = (1 << OUT_WIDTH) - 1;
    localparam int FRAME_LEN  = 1 << OUT_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 start = 1'b0;
    logic                 sn_in = 1'b0;
    logic                 done_in = 1'b0;
    logic                 result_ready = 1'b0;
    logic                 gen_en;
    logic                 busy;
    logic [OUT_WIDTH-1:0] result;
    logic                 result_valid;
    logic                 sat;
    logic                 timeout;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dsc_s2b_capture #(
        .SNG_WIDTH  (SNG_WIDTH),
        .NUM_INPUTS (NUM_INPUTS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .sn_in        (sn_in),
        .done_in      (done_in),
        .gen_en       (gen_en),
        .busy         (busy),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .sat          (sat),
        .timeout      (timeout)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] sn_mask, input int done_at,
                                 input int bp, input bit poke);
        int ones;
        int k;
        int exp_res;
        bit fin;
        bit exp_sat;
        bit exp_to;

        ones = 0;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_gen_en", gen_en, 0);

        start = 1'b1;
        sn_in = 1'b0;
        done_in = 1'b0;
        result_ready = 1'b0;
        step();
        checkOutput("arm_gen_en", gen_en, 1);
        checkOutput("arm_busy", busy, 1);
        checkOutput("arm_valid", result_valid, 0);

        start = poke;
        sn_in = 1'b1;
        done_in = 1'b1;
        step();
        checkOutput("count_acc_clear", result, 0);
        checkOutput("count_sat_clear", sat, 0);
        checkOutput("count_to_clear", timeout, 0);

        k = 0;
        fin = 1'b0;
        while (!fin) begin
            sn_in = sn_mask[k];
            done_in = (k == done_at);
            start = poke & k[0];
            if (sn_mask[k]) ones++;
            fin = (k == done_at) || (k == FRAME_LEN - 1);
            checkOutput("count_gen_en", gen_en, 1);
            checkOutput("count_valid", result_valid, 0);
            step();
            exp_res = (ones > MAX_VAL) ? MAX_VAL : ones;
            checkOutput("count_acc", result, exp_res);
            k++;
        end

        start = 1'b0;
        sn_in = 1'b0;
        done_in = 1'b0;
        exp_sat = (ones > MAX_VAL);
        exp_to = (done_at < 0) || (done_at > FRAME_LEN - 1);

        checkOutput("hold_valid", result_valid, 1);
        checkOutput("hold_result", result, exp_res);
        checkOutput("hold_sat", sat, exp_sat);
        checkOutput("hold_timeout", timeout, exp_to);
        checkOutput("hold_gen_en", gen_en, 0);
        checkOutput("hold_busy", busy, 0);

        for (int i = 0; i < bp; i++) begin
            start = poke;
            sn_in = 1'($urandom);
            done_in = 1'($urandom);
            step();
            checkOutput("bp_valid", result_valid, 1);
            checkOutput("bp_result", result, exp_res);
            checkOutput("bp_busy", busy, 0);
        end

        start = poke;
        sn_in = 1'b0;
        done_in = 1'b0;
        result_ready = 1'b1;
        step();
        checkOutput("accept_valid", result_valid, 0);
        checkOutput("accept_result", result, exp_res);
        checkOutput("accept_sat", sat, exp_sat);
        checkOutput("accept_timeout", timeout, exp_to);

        start = 1'b0;
        result_ready = 1'b0;
        step();
        checkOutput("idle_no_restart", busy, 0);
        checkOutput("idle_result", result, exp_res);
    endtask

    initial begin
        logic [15:0] mask;
        int done_at;

        $display("[TB] start of dsc_s2b_capture bench");

        #12;
        checkOutput("rst_gen_en", gen_en, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_result", result, 0);
        checkOutput("rst_valid", result_valid, 0);
        checkOutput("rst_sat", sat, 0);
        checkOutput("rst_timeout", timeout, 0);
        @(negedge clk);
        rst = 1'b1;
        step();

        // Reset in the middle of a COUNT phase
        start = 1'b1;
        step();
        start = 1'b0;
        sn_in = 1'b1;
        step();
        step();
        step();
        checkOutput("pre_rst_acc", result, 2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_gen_en", gen_en, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_result", result, 0);
        checkOutput("midrst_valid", result_valid, 0);
        sn_in = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
        checkOutput("post_rst_valid", result_valid, 0);
        checkOutput("post_rst_busy", busy, 0);

        // Directed frames
        applyStimulus(16'h015A, 8, 6, 1'b0);
        applyStimulus(16'hFFFF, -1, 0, 1'b0);
        applyStimulus(16'hFFFE, -1, 1, 1'b0);
        applyStimulus(16'hFFFF, 15, 2, 1'b0);
        applyStimulus(16'h7FFF, 15, 0, 1'b0);
        applyStimulus(16'h00F3, 10, 3, 1'b1);
        applyStimulus(16'h0001, 0, 0, 1'b1);

        // Randomized frames
        for (int f = 0; f < 40; f++) begin
            mask = 16'($urandom);
            if ($urandom_range(0, 3) == 0) mask = 16'hFFFF;
            done_at = int'($urandom_range(0, 19));
            applyStimulus(mask, done_at, int'($urandom_range(0, 3)),
                          1'($urandom_range(0, 1)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
